// File: rtl/median3x3_stream.sv
// median3x3_stream: streaming 3x3 median filter with border pass-through and valid/ready handshakes.
// Define ADAPTIVE_MEDIAN_EN to filter only salt/pepper (0 or all-ones) interior centres.
module median3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 430,
    parameter int IMG_H  = 554
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        in_pix,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               State,
    output logic [$clog2(IMG_H)-1:0] Row_o,
    output logic [$clog2(IMG_W)-1:0] Col_o,
    output logic                     done
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int AW = $clog2(IMG_W*IMG_H+1);
    localparam int NW = $clog2(IMG_W+2);
    localparam int LB = 2*IMG_W+2;
    localparam logic [AW-1:0] FILL_LAST = AW'(IMG_W);
    localparam logic [AW-1:0] RUN_LAST  = AW'(IMG_W*IMG_H-1);
    localparam logic [NW-1:0] DRAIN_N   = NW'(IMG_W+1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H-1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W-1);
    // Compare-exchange pairs {lo_idx, hi_idx} of the 19-element median-of-9 network, first pair in the MSBs.
    localparam logic [151:0] PAIRS = 152'h12_45_78_01_34_67_12_45_78_03_58_47_36_14_25_47_42_64_42;

    typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [NW-1:0]     drn_q, drn_d;
    logic [RW-1:0]     gen_r_q, gen_r_d, row_q, row_d;
    logic [CW-1:0]     gen_c_q, gen_c_d, col_q, col_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              vld_q, vld_d, done_q, done_d;
    logic [DATA_W-1:0] lb_q [LB];
    logic [DATA_W-1:0] lb_d [LB];
    logic              slot, accept, load, border, use_med;
    logic [DATA_W-1:0] centre, med;

    function automatic logic [DATA_W-1:0] med9(input logic [9*DATA_W-1:0] w);
        logic [DATA_W-1:0] v [9];
        logic [DATA_W-1:0] t;
        logic [3:0]        a, b;
        for (int i = 0; i < 9; i++) v[i] = w[i*DATA_W +: DATA_W];
        for (int i = 0; i < 19; i++) begin
            a = PAIRS[(18-i)*8+4 +: 4];
            b = PAIRS[(18-i)*8 +: 4];
            if (v[a] > v[b]) begin
                t    = v[a];
                v[a] = v[b];
                v[b] = t;
            end
        end
        return v[4];
    endfunction

    // lb_q[i] holds the pixel accepted i+1 slots ago; in_pix is the window's bottom-right corner.
    always_comb begin
        slot     = !vld_q || out_ready;
        in_ready = (state_q == FILL) || (state_q == RUN && slot);
        accept   = in_valid && in_ready;
        load     = (state_q == RUN && accept) || (state_q == DRAIN && slot && drn_q != '0);
        centre   = lb_q[IMG_W];
        border   = gen_r_q == '0 || gen_r_q == ROW_LAST || gen_c_q == '0 || gen_c_q == COL_LAST;
        med      = med9({in_pix, lb_q[0], lb_q[1],
                         lb_q[IMG_W-1], lb_q[IMG_W], lb_q[IMG_W+1],
                         lb_q[2*IMG_W-1], lb_q[2*IMG_W], lb_q[2*IMG_W+1]});
`ifdef ADAPTIVE_MEDIAN_EN
        use_med  = !border && (centre == '0 || centre == '1);
`else
        use_med  = !border;
`endif
    end

    // Drain loads shift too, so the centre tap keeps walking through the last row.
    always_comb begin
        lb_d[0] = (accept || load) ? in_pix : lb_q[0];
        for (int i = 1; i < LB; i++) lb_d[i] = (accept || load) ? lb_q[i-1] : lb_q[i];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = accept ? acc_q + 1'b1 : acc_q;
        drn_d   = (state_q == DRAIN && load) ? drn_q - 1'b1 : drn_q;
        gen_r_d = gen_r_q;
        gen_c_d = gen_c_q;
        row_d   = load ? gen_r_q : row_q;
        col_d   = load ? gen_c_q : col_q;
        pix_d   = load ? (use_med ? med : centre) : pix_q;
        vld_d   = load || (vld_q && !out_ready);
        if (load) begin
            gen_c_d = (gen_c_q == COL_LAST) ? '0 : gen_c_q + 1'b1;
            gen_r_d = (gen_c_q == COL_LAST) ? gen_r_q + 1'b1 : gen_r_q;
        end
        unique case (state_q)
            IDLE: begin
                acc_d   = '0;
                drn_d   = DRAIN_N;
                gen_r_d = '0;
                gen_c_d = '0;
                state_d = start ? FILL : IDLE;
            end
            FILL:    state_d = (accept && acc_q == FILL_LAST) ? RUN : FILL;
            RUN:     state_d = (accept && acc_q == RUN_LAST) ? DRAIN : RUN;
            DRAIN:   state_d = (drn_q == '0 && vld_q && out_ready) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        lb_q <= lb_d;
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            drn_q   <= '0;
            gen_r_q <= '0;
            gen_c_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            drn_q   <= drn_d;
            gen_r_q <= gen_r_d;
            gen_c_q <= gen_c_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign out_pix   = pix_q;
    assign out_valid = vld_q;
    assign State     = state_q;
    assign Row_o     = row_q;
    assign Col_o     = col_q;
    assign done      = done_q;
endmodule

// File: tb/tb_median3x3_stream.sv
// tb_median3x3_stream: scoreboard bench for median3x3_stream on 4x4 frames of 8-bit pixels.
module tb_median3x3_stream;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W*H;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic [7:0] in_pix;
    logic       in_ready, out_valid, done;
    logic [7:0] out_pix;
    logic [2:0] state;
    logic [1:0] row_o, col_o;

    median3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
        .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready),
        .State(state), .Row_o(row_o), .Col_o(col_o), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        int         idx;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] img [N];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int j);
        int         r, c, n;
        logic [7:0] v [9];
        logic [7:0] t;
        r = j / W;
        c = j % W;
        n = 0;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return img[j];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[n] = img[(r+dr)*W + c + dc];
                n++;
            end
        for (int a = 1; a < 9; a++)
            for (int b = a; b > 0 && v[b-1] > v[b]; b--) begin
                t      = v[b];
                v[b]   = v[b-1];
                v[b-1] = t;
            end
`ifdef ADAPTIVE_MEDIAN_EN
        if (img[j] != 8'd0 && img[j] != 8'hFF) return img[j];
`endif
        return v[4];
    endfunction

    task automatic push(input int j);
        exp_t e;
        e.pix = ref_pix(j);
        e.idx = j;
        sb.push_back(e);
    endtask

    task automatic run_frame(input int stall_at, input int abort_at, input bit rnd);
        int         k, dones, last_idx, drain_cyc, done_cyc;
        logic [7:0] hp;
        logic [1:0] hr, hc;
        exp_t       e;
        k = 0; dones = 0; last_idx = -1; drain_cyc = -1; done_cyc = -1;
        hp = '0; hr = '0; hc = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            rst       = !(cyc == abort_at);
            start     = (cyc == 0);
            in_valid  = (k < N) && !(rnd && $urandom_range(0, 3) == 0);
            in_pix    = (k < N) ? img[k] : 8'd0;
            out_ready = rnd ? ($urandom_range(0, 2) != 0)
                            : !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 5);
            #1;
            if (cyc == abort_at) continue;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                check("rst_state", state, 0);
                check("rst_valid", out_valid, 0);
                check("rst_ready", in_ready, 0);
                check("rst_pix", out_pix, 0);
                check("rst_row", row_o, 0);
                check("rst_col", col_o, 0);
                check("rst_done", done, 0);
                sb.delete();
                return;
            end
            if (stall_at > 0 && cyc == stall_at) begin
                check("stall_valid", out_valid, 1);
                hp = out_pix; hr = row_o; hc = col_o;
            end
            if (stall_at > 0 && cyc >= stall_at && cyc < stall_at + 5) check("stall_ready", in_ready, 0);
            if (stall_at > 0 && cyc > stall_at && cyc < stall_at + 5) begin
                check("stall_pix", out_pix, hp);
                check("stall_row", row_o, hr);
                check("stall_col", col_o, hc);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("extra_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("pix", out_pix, e.pix);
                    check("row", row_o, e.idx / W);
                    check("col", col_o, e.idx % W);
                    if (e.idx > N - W - 2) check("drain_out_state", state, 3);
                    last_idx = e.idx;
                end
            end
            if (done) begin
                dones++;
                check("done_state", state, 4);
                check("done_last", last_idx, N - 1);
                check("done_empty", sb.size(), 0);
                done_cyc = cyc;
            end else if (done_cyc >= 0) begin
                check("idle_after_done", state, 0);
                break;
            end
            if (in_valid && in_ready) begin
                if (k >= W + 1) push(k - W - 1);
                k++;
                if (k == N) begin
                    for (int j = N - W - 1; j < N; j++) push(j);
                    drain_cyc = cyc + 1;
                end
            end
            if (cyc == drain_cyc) begin
                check("drain_state", state, 3);
                check("drain_ready", in_ready, 0);
            end
        end
        check("done_count", dones, 1);
        if (!rnd && stall_at <= 0) check("latency", done_cyc, N + W + 3);
    endtask

    task automatic fill_img(input logic [7:0] v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    initial begin
        int seen;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pix = '0;
        repeat (3) @(negedge clk);
        check("init_state", state, 0);
        check("init_valid", out_valid, 0);
        check("init_ready", in_ready, 0);
        check("init_done", done, 0);
        rst = 1'b1;

        fill_img(8'd100); img[5] = 8'd255;
        run_frame(0, -1, 1'b0);

        fill_img(8'd100); img[0] = 8'd255; img[14] = 8'd0;
        run_frame(0, -1, 1'b0);

        fill_img(8'd100); img[5] = 8'd255;
        run_frame(9, -1, 1'b0);

        fill_img(8'd200); img[10] = 8'd50;
        run_frame(0, -1, 1'b0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
            img[$urandom_range(5, 6)] = 8'd0;
            img[$urandom_range(9, 10)] = 8'd255;
            run_frame(0, -1, 1'b1);
        end

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(0, 10, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            if (out_valid) seen++;
        end
        check("no_out_after_rst", seen, 0);
        check("idle_after_rst", state, 0);

        fill_img(8'd100); img[5] = 8'd255;
        run_frame(0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
